mux_4: RTL and testbench

- Parameterised 4:1 data selector for the single-cycle ARM datapath, e.g. result/operand source selection.
- Primary output y is purely combinational: it selects one of d0..d3 by the 2-bit sel.
- A registered copy, y_r, is also provided for pipelined or timing-relaxed consumers.
- The register is clocked by clk, uses an asynchronous active-high reset, and is gated by an enable.

---
 rtl/mux_pkg.sv | 18 +
 rtl/mux_4_if.sv | 51 +++++
 rtl/mux_4_flopenr.sv | 32 +++
 rtl/mux_4.sv | 54 +++++
 tb/tb_mux_4.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the 4:1 datapath selector.
//   sel_e         : the four select codes, one per data input
//   DEFAULT_WIDTH : data width used when a user does not override WIDTH
// -----------------------------------------------------------------------------
package mux_pkg;

  typedef enum logic [1:0] {
    SEL_D0 = 2'b00,
    SEL_D1 = 2'b01,
    SEL_D2 = 2'b10,
    SEL_D3 = 2'b11
  } sel_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage : mux_pkg

// File: rtl/mux_4_if.sv
// -----------------------------------------------------------------------------
// mux_4_if
// Bundles the data, select and enable inputs of the selector together with
// its combinational and registered results.
//   en      : load enable for the registered result (idles at 1)
//   d0..d3  : data inputs, WIDTH bits each (d1 idles at 0)
//   sel     : 2-bit select code, see mux_pkg::sel_e
//   y       : combinational selected data
//   y_r     : registered selected data
// Modports:
//   master : the side that sources data/select and consumes results
//   slave  : the selector itself
// en and d1 carry initial values so a consumer that never drives them sees
// the documented defaults (en=1, d1=0).
// -----------------------------------------------------------------------------
interface mux_4_if #(
  parameter int WIDTH = mux_pkg::DEFAULT_WIDTH
);

  logic             en = 1'b1;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1 = '0;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic [1:0]       sel;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_r;

  modport master (
    output en,
    output d0,
    output d1,
    output d2,
    output d3,
    output sel,
    input  y,
    input  y_r
  );

  modport slave (
    input  en,
    input  d0,
    input  d1,
    input  d2,
    input  d3,
    input  sel,
    output y,
    output y_r
  );

endinterface : mux_4_if

// File: rtl/mux_4_flopenr.sv
// -----------------------------------------------------------------------------
// flopenr
// WIDTH-wide register with load enable and asynchronous active-high reset.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears q immediately, dominates en
//   en    : when high, q loads d on the rising edge; otherwise q holds
//   d     : next value
//   q     : registered value
// -----------------------------------------------------------------------------
module flopenr #(
  parameter int WIDTH = mux_pkg::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule : flopenr

// File: rtl/mux_4.sv
// -----------------------------------------------------------------------------
// mux_4
// 4:1 data selector for operand/result source selection, with an optional
// registered copy of the selected value.
//   clk   : rising-edge clock for y_r
//   reset : asynchronous, active-high; clears y_r only
//   bus   : mux_4_if.slave
//             en, d0..d3, sel in; y (combinational), y_r (registered) out
// WIDTH must match the WIDTH of the connected interface instance (1..64).
// -----------------------------------------------------------------------------
module mux_4
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic    clk,
  input  logic    reset,
  mux_4_if.slave  bus
);

  logic [WIDTH-1:0] y_next;
  logic [WIDTH-1:0] y_r_q;

  // The selector has no dependence on clk/reset/en. An unknown select code
  // falls to the default branch, so simulation shows all-X on y while
  // synthesis is free to treat it as don't-care.
  always_comb begin
    y_next = 'x;
    unique case (sel_e'(bus.sel))
      SEL_D0:  y_next = bus.d0;
      SEL_D1:  y_next = bus.d1;
      SEL_D2:  y_next = bus.d2;
      SEL_D3:  y_next = bus.d3;
      default: y_next = 'x;
    endcase
  end

  assign bus.y = y_next;

  // The register samples the combinational result, so y_r is y delayed by
  // exactly one enabled clock edge.
  flopenr #(
    .WIDTH (WIDTH)
  ) u_yr (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .d     (y_next),
    .q     (y_r_q)
  );

  assign bus.y_r = y_r_q;

endmodule : mux_4

// File: tb/tb_mux_4.sv
module tb_mux_4;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic done = 1'b0;
    always #5 clk = ~clk;

    mux_4_if #(.WIDTH(8))  b8 ();
    mux_4_if #(.WIDTH(32)) b32 ();

    mux_4 #(.WIDTH(8)) u8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b8)
    );

    // 32-bit instance: d1 and en are never driven, exercising their defaults.
    mux_4 #(.WIDTH(32)) u32 (
        .clk   (clk),
        .reset (reset),
        .bus   (b32)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        int          kind;   // 0: b8.y  1: b8.y_r  2: b32.y  3: b32.y_r
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    event chk_ev;
    int   n_pass  = 0;
    int   n_total = 0;

    // Monitor: drains the expectation queue whenever stimulus posts a sample.
    initial begin
        forever begin
            @(chk_ev);
            while (q.size() > 0) begin
                chk_t        c;
                logic [31:0] act;
                c = q.pop_front();
                case (c.kind)
                    0:       act = {24'h0, b8.y};
                    1:       act = {24'h0, b8.y_r};
                    2:       act = b32.y;
                    default: act = b32.y_r;
                endcase
                n_total++;
                if (act === c.exp) begin
                    n_pass++;
                    $display("check %s: got %h expected %h ok", c.name, act, c.exp);
                end else begin
                    $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
                end
            end
        end
    end

    // Watchdog: the sequence must complete well within this bound.
    initial begin
        #20000;
        if (!done) begin
            $display("FAIL timeout: test sequence did not complete within 20000 ns");
            $finish;
        end
    end

    task automatic expect_val(input string name, input int kind, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.kind = kind;
        c.exp  = exp;
        q.push_back(c);
        ->chk_ev;
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [7:0] dv [4];
    logic [1:0] sel8;
    logic [7:0] yr_model;

    task automatic apply8();
        b8.d0  = dv[0];
        b8.d1  = dv[1];
        b8.d2  = dv[2];
        b8.d3  = dv[3];
        b8.sel = sel8;
    endtask

    initial begin
        reset   = 1'b1;
        b8.en   = 1'b1;
        dv[0]   = 8'h01; dv[1] = 8'h02; dv[2] = 8'h04; dv[3] = 8'h08;
        sel8    = 2'd0;
        apply8();
        b32.d0  = 32'h1111_1111;
        b32.d2  = 32'h2222_2222;
        b32.d3  = 32'h0;
        b32.sel = 2'd0;
        #1;
        if (b8.y_r !== 8'h00 || b32.y_r !== 32'h0) begin
            $display("FAIL reset_state: y_r8 %h y_r32 %h expected 0", b8.y_r, b32.y_r);
        end else begin
            $display("check reset_state: y_r8 %h y_r32 %h ok", b8.y_r, b32.y_r);
        end
        expect_val("reset_yr8", 1, 32'h00);
        expect_val("reset_yr32", 3, 32'h00);

        // Selection steps, no clock edge needed.
        for (int s = 0; s < 4; s++) begin
            sel8 = 2'(s);
            apply8();
            #1;
            expect_val($sformatf("sel_%0d", s), 0, {24'h0, dv[s]});
            #8;
        end

        // sel=10 fixed: only d2 affects y.
        sel8 = 2'd2; dv[2] = 8'hA5; apply8(); #1;
        expect_val("d2_follow", 0, 32'hA5);
        dv[0] = 8'h5A; apply8(); #1;
        expect_val("d0_ignored", 0, 32'hA5);
        dv[1] = 8'h3C; apply8(); #1;
        expect_val("d1_ignored", 0, 32'hA5);
        dv[3] = 8'hC3; apply8(); #1;
        expect_val("d3_ignored", 0, 32'hA5);
        dv[0] = 8'h01; dv[1] = 8'h02; dv[2] = 8'h04; dv[3] = 8'h08; apply8();

        // Reset held with en=1 while clocking.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            expect_val($sformatf("reset_hold_%0d", i), 1, 32'h00);
        end

        // Release reset; y_r only updates on the next rising edge.
        @(negedge clk);
        reset = 1'b0;
        sel8 = 2'd3; apply8(); #1;
        expect_val("yr_before_edge", 1, 32'h00);
        @(posedge clk); #1;
        expect_val("yr_after_edge", 1, 32'h08);

        // en=0 holds through three edges.
        @(negedge clk);
        b8.en = 1'b0;
        sel8 = 2'd0; apply8(); #1;
        expect_val("y_sel0_en0", 0, 32'h01);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            expect_val($sformatf("en0_hold_%0d", i), 1, 32'h08);
        end
        @(negedge clk);
        b8.en = 1'b1;
        @(posedge clk); #1;
        expect_val("en1_load", 1, 32'h01);

        // Asynchronous reset between edges, then held across an enabled edge.
        @(negedge clk); #2;
        reset = 1'b1; #1;
        expect_val("async_reset", 1, 32'h00);
        @(posedge clk); #1;
        expect_val("reset_over_en", 1, 32'h00);

        // 32-bit instance with d1 and en left at defaults.
        b32.sel = 2'd1; #1;
        expect_val("d1_default", 2, 32'h0);
        b32.d3 = 32'hDEADBEEF; b32.sel = 2'd3; #1;
        expect_val("w32_sel3", 2, 32'hDEADBEEF);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        expect_val("w32_yr_en_default", 3, 32'hDEADBEEF);

        // Randomised traffic on the 8-bit instance; first pass starts in reset.
        yr_model = 8'h00;
        for (int it = 0; it < 60; it++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) dv[k] = 8'($urandom);
            sel8  = 2'($urandom_range(0, 3));
            b8.en = ($urandom_range(0, 3) != 0);
            reset = (it == 0) || ($urandom_range(0, 7) == 0);
            apply8();
            if (reset) yr_model = 8'h00;
            #1;
            expect_val($sformatf("rnd_y_%0d", it), 0, {24'h0, dv[sel8]});
            expect_val($sformatf("rnd_yr_pre_%0d", it), 1, {24'h0, yr_model});
            @(posedge clk);
            if (!reset && b8.en) yr_model = dv[sel8];
            #1;
            expect_val($sformatf("rnd_yr_post_%0d", it), 1, {24'h0, yr_model});
        end

        #5;
        done = 1'b1;
        if (n_pass != n_total) begin
            $display("FAIL summary: %0d/%0d checks passed", n_pass, n_total);
        end else begin
            $display("%0d/%0d checks passed", n_pass, n_total);
        end
        $finish;
    end

endmodule : tb_mux_4
